// File: rtl/ecc_sed_checker.sv
// Single-error-detecting (even parity) checker feeding a 2-entry in-order FIFO,
// with a saturating error counter and a sticky error flag.
module ecc_sed_checker #(
  parameter int DATA_W   = 12,
  parameter int CNT_W    = 8,
  parameter bit DROP_ERR = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enc_valid,
  output logic              enc_ready,
  input  logic [DATA_W:0]   enc_codeword,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [DATA_W-1:0] dec_data,
  output logic              dec_err,
  output logic [CNT_W-1:0]  err_count,
  output logic              err_sticky,
  input  logic              clr_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Each entry holds {err, data}.
  logic [DATA_W:0]    mem_reg [2];
  logic               wr_ptr_reg;
  logic               rd_ptr_reg;
  logic [1:0]         occ_reg;
  logic [1:0]         occ_next;
  logic               enc_ready_reg;
  logic [CNT_W-1:0]   err_count_reg;
  logic [CNT_W-1:0]   err_count_next;
  logic               err_sticky_reg;
  logic               err_sticky_next;

  logic               accept;
  logic               parity_err;
  logic               accept_err;
  logic               push;
  logic               pop;

  assign parity_err = ^enc_codeword;
  assign accept     = enc_valid & enc_ready_reg;
  assign accept_err = accept & parity_err;
  // Errored words are still counted when dropped; only the FIFO write is suppressed.
  assign push       = accept & ~(DROP_ERR & parity_err);
  assign pop        = dec_valid & dec_ready;

  assign occ_next   = occ_reg + 2'(push) - 2'(pop);

  always_comb begin
    err_count_next  = err_count_reg;
    err_sticky_next = err_sticky_reg;
    if (clr_err) begin
      err_count_next  = '0;
      err_sticky_next = 1'b0;
    end
    // Applied after the clear so a coincident clear and error leaves a count of one.
    if (accept_err) begin
      if (err_count_next != CNT_MAX) begin
        err_count_next = err_count_next + CNT_W'(1);
      end
      err_sticky_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
      occ_reg        <= 2'd0;
      enc_ready_reg  <= 1'b0;
      err_count_reg  <= '0;
      err_sticky_reg <= 1'b0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= {parity_err, enc_codeword[DATA_W-1:0]};
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      occ_reg        <= occ_next;
      enc_ready_reg  <= (occ_next < 2'd2);
      err_count_reg  <= err_count_next;
      err_sticky_reg <= err_sticky_next;
    end
  end

  assign enc_ready  = enc_ready_reg;
  assign dec_valid  = (occ_reg != 2'd0);
  assign dec_data   = mem_reg[rd_ptr_reg][DATA_W-1:0];
  assign dec_err    = mem_reg[rd_ptr_reg][DATA_W];
  assign err_count  = err_count_reg;
  assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_ecc_sed_checker.sv
// Directed bench for ecc_sed_checker: default instance plus a DROP_ERR=1 instance.
module tb_ecc_sed_checker;

  logic        clk;
  logic        rst;

  logic        enc_valid;
  logic        enc_ready;
  logic [12:0] enc_codeword;
  logic        dec_valid;
  logic        dec_ready;
  logic [11:0] dec_data;
  logic        dec_err;
  logic [7:0]  err_count;
  logic        err_sticky;
  logic        clr_err;

  logic        enc_valid2;
  logic        enc_ready2;
  logic [12:0] enc_codeword2;
  logic        dec_valid2;
  logic        dec_ready2;
  logic [11:0] dec_data2;
  logic        dec_err2;
  logic [7:0]  err_count2;
  logic        err_sticky2;
  logic        clr_err2;

  int total = 0;
  int bad   = 0;

  ecc_sed_checker #(.DATA_W(12), .CNT_W(8), .DROP_ERR(1'b0)) dut (
    .clk(clk), .rst(rst),
    .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_codeword(enc_codeword),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_data(dec_data), .dec_err(dec_err),
    .err_count(err_count), .err_sticky(err_sticky), .clr_err(clr_err)
  );

  ecc_sed_checker #(.DATA_W(12), .CNT_W(8), .DROP_ERR(1'b1)) dut_drop (
    .clk(clk), .rst(rst),
    .enc_valid(enc_valid2), .enc_ready(enc_ready2), .enc_codeword(enc_codeword2),
    .dec_valid(dec_valid2), .dec_ready(dec_ready2), .dec_data(dec_data2), .dec_err(dec_err2),
    .err_count(err_count2), .err_sticky(err_sticky2), .clr_err(clr_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    enc_valid = 1'b0; enc_codeword = '0; dec_ready = 1'b0; clr_err = 1'b0;
    enc_valid2 = 1'b0; enc_codeword2 = '0; dec_ready2 = 1'b1; clr_err2 = 1'b0;
    tick(); tick();
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL rst_dec_valid got=%b want=0", dec_valid); end
    total++; if (enc_ready !== 1'b0) begin bad++; $display("FAIL rst_enc_ready got=%b want=0", enc_ready); end
    total++; if (dec_data !== 12'h000) begin bad++; $display("FAIL rst_dec_data got=%h want=000", dec_data); end
    total++; if (dec_err !== 1'b0) begin bad++; $display("FAIL rst_dec_err got=%b want=0", dec_err); end
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL rst_err_count got=%0d want=0", err_count); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL rst_err_sticky got=%b want=0", err_sticky); end
    rst = 1'b1;
    #1;
    total++; if (enc_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_before_edge got=%b want=0", enc_ready); end
    tick();
    total++; if (enc_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_first_edge got=%b want=1", enc_ready); end
    $display("txn reset released");
  endtask

  task automatic test_good_word();
    dec_ready = 1'b1; enc_valid = 1'b1; enc_codeword = 13'h1001;
    tick();
    enc_valid = 1'b0;
    $display("txn push 1001");
    total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL good_dec_valid got=%b want=1", dec_valid); end
    total++; if (dec_data !== 12'h001) begin bad++; $display("FAIL good_dec_data got=%h want=001", dec_data); end
    total++; if (dec_err !== 1'b0) begin bad++; $display("FAIL good_dec_err got=%b want=0", dec_err); end
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL good_err_count got=%0d want=0", err_count); end
    tick();
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL good_drain got=%b want=0", dec_valid); end
  endtask

  task automatic test_bad_word();
    enc_valid = 1'b1; enc_codeword = 13'h0001;
    tick();
    enc_valid = 1'b0;
    $display("txn push 0001");
    total++; if (dec_data !== 12'h001) begin bad++; $display("FAIL bad_dec_data got=%h want=001", dec_data); end
    total++; if (dec_err !== 1'b1) begin bad++; $display("FAIL bad_dec_err got=%b want=1", dec_err); end
    total++; if (err_count !== 8'd1) begin bad++; $display("FAIL bad_err_count got=%0d want=1", err_count); end
    total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL bad_err_sticky got=%b want=1", err_sticky); end
    tick();
  endtask

  task automatic test_backpressure();
    dec_ready = 1'b0; enc_valid = 1'b1; enc_codeword = 13'h0003;
    tick();
    $display("txn push 0003");
    total++; if (enc_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_one got=%b want=1", enc_ready); end
    enc_codeword = 13'h0005;
    tick();
    $display("txn push 0005");
    total++; if (enc_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b want=0", enc_ready); end
    enc_codeword = 13'h0006;
    tick();
    total++; if (enc_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_held got=%b want=0", enc_ready); end
    total++; if (dec_data !== 12'h003) begin bad++; $display("FAIL bp_head_stable got=%h want=003", dec_data); end
    dec_ready = 1'b1;
    tick();
    $display("txn pop 003");
    total++; if (dec_data !== 12'h005) begin bad++; $display("FAIL bp_second got=%h want=005", dec_data); end
    total++; if (enc_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_reopen got=%b want=1", enc_ready); end
    tick();
    enc_valid = 1'b0;
    $display("txn push 0006 pop 005");
    total++; if (dec_data !== 12'h006 || dec_valid !== 1'b1) begin bad++; $display("FAIL bp_third got=%h/%b want=006/1", dec_data, dec_valid); end
    total++; if (dec_err !== 1'b0) begin bad++; $display("FAIL bp_third_err got=%b want=0", dec_err); end
    tick();
    $display("txn pop 006");
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", dec_valid); end
  endtask

  task automatic test_saturation();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    total++; if (err_count !== 8'd0 || err_sticky !== 1'b0) begin bad++; $display("FAIL clr_only got=%0d/%b want=0/0", err_count, err_sticky); end
    dec_ready = 1'b1; enc_valid = 1'b1; enc_codeword = 13'h0001;
    repeat (254) tick();
    $display("txn stream 254 errored");
    total++; if (err_count !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d want=254", err_count); end
    repeat (46) tick();
    $display("txn stream 46 errored");
    total++; if (err_count !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d want=255", err_count); end
    clr_err = 1'b1;
    tick();
    $display("txn clr with errored push");
    total++; if (err_count !== 8'd1 || err_sticky !== 1'b1) begin bad++; $display("FAIL clr_coincident got=%0d/%b want=1/1", err_count, err_sticky); end
    enc_valid = 1'b0;
    tick();
    clr_err = 1'b0;
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL clr_after got=%0d want=0", err_count); end
    tick();
  endtask

  task automatic test_drop_err();
    enc_valid2 = 1'b1; enc_codeword2 = 13'h1001;
    tick();
    $display("txn drop push good 001");
    total++; if (dec_valid2 !== 1'b1 || dec_data2 !== 12'h001) begin bad++; $display("FAIL drop_first got=%b/%h want=1/001", dec_valid2, dec_data2); end
    enc_codeword2 = 13'h0001;
    tick();
    $display("txn drop push bad 001");
    total++; if (dec_valid2 !== 1'b0) begin bad++; $display("FAIL drop_discard got=%b want=0", dec_valid2); end
    total++; if (err_count2 !== 8'd1) begin bad++; $display("FAIL drop_count got=%0d want=1", err_count2); end
    total++; if (enc_ready2 !== 1'b1) begin bad++; $display("FAIL drop_ready got=%b want=1", enc_ready2); end
    enc_codeword2 = 13'h0003;
    tick();
    enc_valid2 = 1'b0;
    $display("txn drop push good 003");
    total++; if (dec_valid2 !== 1'b1 || dec_data2 !== 12'h003 || dec_err2 !== 1'b0) begin bad++; $display("FAIL drop_second got=%b/%h/%b want=1/003/0", dec_valid2, dec_data2, dec_err2); end
    tick();
    total++; if (dec_valid2 !== 1'b0 || err_count2 !== 8'd1) begin bad++; $display("FAIL drop_end got=%b/%0d want=0/1", dec_valid2, err_count2); end
  endtask

  task automatic test_reset_mid();
    dec_ready = 1'b0; enc_valid = 1'b1; enc_codeword = 13'h0001;
    tick();
    enc_codeword = 13'h0003;
    tick();
    enc_valid = 1'b0;
    $display("txn fill fifo");
    total++; if (enc_ready !== 1'b0 || err_count !== 8'd1) begin bad++; $display("FAIL mid_full got=%b/%0d want=0/1", enc_ready, err_count); end
    rst = 1'b0;
    #1;
    $display("txn async reset");
    total++; if (dec_valid !== 1'b0 || err_count !== 8'd0) begin bad++; $display("FAIL mid_async got=%b/%0d want=0/0", dec_valid, err_count); end
    total++; if (dec_data !== 12'h000 || err_sticky !== 1'b0) begin bad++; $display("FAIL mid_async_data got=%h/%b want=000/0", dec_data, err_sticky); end
    tick();
    rst = 1'b1; dec_ready = 1'b1;
    tick();
    total++; if (dec_valid !== 1'b0 || enc_ready !== 1'b1) begin bad++; $display("FAIL mid_release got=%b/%b want=0/1", dec_valid, enc_ready); end
    tick();
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL mid_idle got=%b want=0", dec_valid); end
    enc_valid = 1'b1; enc_codeword = 13'h0005;
    tick();
    enc_valid = 1'b0;
    $display("txn push 0005 after reset");
    total++; if (dec_valid !== 1'b1 || dec_data !== 12'h005) begin bad++; $display("FAIL mid_new got=%b/%h want=1/005", dec_valid, dec_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_good_word();
    test_bad_word();
    test_backpressure();
    test_saturation();
    test_drop_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ecc_sed_checker.md
ECC_SED_CHECKER -- requirements
Module: ecc_sed_checker

Interface
REQ-001 Parameter DATA_W, default 12, payload width; codeword width is DATA_W+1.
REQ-002 Parameter CNT_W, default 8, width of the error counter.
REQ-003 Parameter DROP_ERR, default 0; 1 = discard errored words, 0 = forward them with dec_err set.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; asynchronous assert, active-low; deassertion is synchronous to clk.
REQ-006 enc_valid  input  1  upstream codeword valid.
REQ-007 enc_ready  output  1  block can accept a codeword this cycle.
REQ-008 enc_codeword  input  DATA_W+1  {parity, data}; bit DATA_W is parity.
REQ-009 dec_valid  output  1  output word valid.
REQ-010 dec_ready  input  1  downstream accepts output word.
REQ-011 dec_data  output  DATA_W  payload, enc_codeword[DATA_W-1:0].
REQ-012 dec_err  output  1  parity error flag for the word on dec_data.
REQ-013 err_count  output  CNT_W  saturating count of errored codewords accepted.
REQ-014 err_sticky  output  1  set on any accepted errored codeword; held until cleared.
REQ-015 clr_err  input  1  synchronous clear of err_count and err_sticky.

Function
REQ-016 Even parity: a codeword is error-free iff the XOR of all DATA_W+1 bits is 0.
REQ-017 Parity check is performed at acceptance (enc_valid & enc_ready); the result is stored with the payload.
REQ-018 Storage is a 2-entry in-order FIFO of {data, err}; enc_ready = (occupancy < 2), registered, not combinational from dec_ready.
REQ-019 dec_valid = (occupancy > 0); dec_data/dec_err present the head entry; both change only after a pop or when going non-empty.
REQ-020 Latency: a word accepted in cycle N into an empty FIFO appears on dec_valid in cycle N+1.
REQ-021 Pop occurs on dec_valid & dec_ready; simultaneous push and pop leaves occupancy unchanged and preserves order.
REQ-022 Full (occupancy 2): enc_ready low; enc_valid ignored; no data loss, no overwrite.
REQ-023 Empty: dec_ready ignored; dec_data/dec_err hold last value, undefined to consumer.
REQ-024 dec_valid, once high, stays high with stable dec_data/dec_err until popped.
REQ-025 DROP_ERR=1: errored accepted words are not written to the FIFO but are still counted; enc_ready behaviour unchanged.
REQ-026 err_count increments by 1 per accepted errored codeword; saturates at 2^CNT_W-1, no wrap.
REQ-027 err_sticky sets in the cycle after an accepted errored codeword.
REQ-028 clr_err and an accepted errored codeword in the same cycle: clear applied first, then increment -> err_count=1, err_sticky=1.
REQ-029 clr_err does not affect FIFO contents, dec_valid or dec_err.

Reset
REQ-030 While rst is low: FIFO occupancy 0, dec_valid=0, enc_ready=0, dec_data=0, dec_err=0, err_count=0, err_sticky=0.
REQ-031 enc_ready rises in the first clk edge after rst deasserts.
REQ-032 Reset asserted mid-operation discards all buffered words immediately (asynchronously); no partial word is emitted afterwards.

Verification
REQ-033 Good word: dec_ready=1, push 13'h1001 -> next cycle dec_valid=1, dec_data=12'h001, dec_err=0, err_count=0.
REQ-034 Bad word: push 13'h0001 -> dec_data=12'h001, dec_err=1, err_count=1, err_sticky=1.
REQ-035 Backpressure: dec_ready=0, push 3 words 12'h003/12'h005/12'h006 (valid parity) -> enc_ready low after 2nd; 3rd held; release dec_ready -> outputs 003,005,006 in order, no loss.
REQ-036 Saturation: CNT_W=8, push 300 errored words -> err_count=255; clr_err coincident with an errored push -> err_count=1.
REQ-037 DROP_ERR=1: push good, bad, good -> only the two good words appear on dec_data; err_count=1.
REQ-038 Reset mid-stream: FIFO full, pull rst low -> dec_valid=0 and err_count=0 immediately; after release, dec_valid stays 0 until a new push.
